// File: rtl/gamepad_input_conditioner.sv
// gamepad_input_conditioner
// Conditions raw gamepad buttons for the pixel generator. Each channel goes
// through polarity normalisation, a 2-flop synchroniser and a debouncer.
// From the debounced level it derives press/release pulses, auto-repeat
// pulses and per-frame snapshots latched on frame_tick.
module gamepad_input_conditioner #(
   parameter int                 N_BTN           = 5,
   parameter logic [N_BTN-1:0]   ACTIVE_LOW_MASK = 5'b01111,
   parameter int                 DEBOUNCE_CYCLES = 500000,
   parameter int                 REPEAT_DELAY    = 25000000,
   parameter int                 REPEAT_PERIOD   = 5000000
) (
   input  logic             clk_50MHz,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic             frame_tick,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat,
   output logic [N_BTN-1:0] btn_frame,
   output logic [N_BTN-1:0] btn_frame_press
);

   localparam int DW     = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW     = $clog2(RMAX) + 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT
   } rep_state_t;

   logic [N_BTN-1:0] w_norm;
   logic [N_BTN-1:0] r_sync1;
   logic [N_BTN-1:0] r_sync2;
   logic [N_BTN-1:0] r_level;
   logic [DW-1:0]    r_dcnt [N_BTN];
   logic [N_BTN-1:0] w_diff;
   logic [N_BTN-1:0] w_accept;
   logic [N_BTN-1:0] w_rise;
   logic [N_BTN-1:0] w_fall;
   logic [N_BTN-1:0] r_press;
   logic [N_BTN-1:0] r_release;

   rep_state_t       r_state     [N_BTN];
   rep_state_t       w_state_nxt [N_BTN];
   logic [RW-1:0]    r_rcnt      [N_BTN];
   logic [RW-1:0]    w_rcnt_nxt  [N_BTN];
   logic [N_BTN-1:0] w_rep_nxt;
   logic [N_BTN-1:0] r_repeat;

   logic [N_BTN-1:0] r_acc;
   logic [N_BTN-1:0] r_frame;
   logic [N_BTN-1:0] r_frame_press;

   assign w_norm = btn_raw ^ ACTIVE_LOW_MASK;

   // Two-flop synchroniser; reset value 0 is the released state after polarity fix
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_norm;
         r_sync2 <= r_sync1;
      end
   end

   // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching sample
   always_comb begin
      w_diff = r_sync2 ^ r_level;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         w_accept[i] = w_diff[i] && (r_dcnt[i] == DB_LAST);
      end
      w_rise = w_accept & r_sync2;
      w_fall = w_accept & ~r_sync2;
   end

   // Debounce counters, debounced level and edge pulses
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         r_level   <= '0;
         r_press   <= '0;
         r_release <= '0;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            r_dcnt[i] <= '0;
         end
      end else begin
         r_level   <= r_level ^ w_accept;
         r_press   <= w_rise;
         r_release <= w_fall;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            if (!w_diff[i] || w_accept[i]) begin
               r_dcnt[i] <= '0;
            end else begin
               r_dcnt[i] <= r_dcnt[i] + 1'b1;
            end
         end
      end
   end

   // Repeat FSM state register and registered repeat pulse
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         r_repeat <= '0;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            r_state[i] <= ST_IDLE;
            r_rcnt[i]  <= '0;
         end
      end else begin
         r_repeat <= w_rep_nxt;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_rcnt[i]  <= w_rcnt_nxt[i];
         end
      end
   end

   // Repeat FSM next state; the FSM reacts to the accept condition so the first
   // repeat pulse lines up with the press pulse
   always_comb begin
      w_rep_nxt = '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         w_state_nxt[i] = r_state[i];
         w_rcnt_nxt[i]  = r_rcnt[i];
         if (w_fall[i]) begin
            w_state_nxt[i] = ST_IDLE;
            w_rcnt_nxt[i]  = '0;
         end else begin
            case (r_state[i])
               ST_IDLE: begin
                  if (w_rise[i]) begin
                     w_rep_nxt[i]   = 1'b1;
                     w_state_nxt[i] = ST_DELAY;
                     w_rcnt_nxt[i]  = '0;
                  end
               end
               ST_DELAY: begin
                  if (r_rcnt[i] == RD_LAST) begin
                     w_rep_nxt[i]   = 1'b1;
                     w_state_nxt[i] = ST_REPEAT;
                     w_rcnt_nxt[i]  = '0;
                  end else begin
                     w_rcnt_nxt[i] = r_rcnt[i] + 1'b1;
                  end
               end
               ST_REPEAT: begin
                  if (r_rcnt[i] == RP_LAST) begin
                     w_rep_nxt[i]  = 1'b1;
                     w_rcnt_nxt[i] = '0;
                  end else begin
                     w_rcnt_nxt[i] = r_rcnt[i] + 1'b1;
                  end
               end
               default: begin
                  w_state_nxt[i] = ST_IDLE;
                  w_rcnt_nxt[i]  = '0;
               end
            endcase
         end
      end
   end

   // Frame snapshots; a press pulse coincident with frame_tick closes into the ending frame
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         r_acc         <= '0;
         r_frame       <= '0;
         r_frame_press <= '0;
      end else if (frame_tick) begin
         r_frame       <= r_level;
         r_frame_press <= r_acc | r_press;
         r_acc         <= '0;
      end else begin
         r_acc         <= r_acc | r_press;
      end
   end

   assign btn_level       = r_level;
   assign btn_press       = r_press;
   assign btn_release     = r_release;
   assign btn_repeat      = r_repeat;
   assign btn_frame       = r_frame;
   assign btn_frame_press = r_frame_press;

endmodule

// File: tb/tb_gamepad_input_conditioner.sv
// Bench for gamepad_input_conditioner: directed scenarios followed by random
// stimulus, every cycle compared against a timestamp-based reference model.
module tb_gamepad_input_conditioner;

   localparam int         N    = 5;
   localparam logic [4:0] MASK = 5'b01111;
   localparam int         D    = 4;
   localparam int         RD   = 10;
   localparam int         RP   = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] btn_raw = MASK;
   logic       frame_tick = 1'b0;
   logic [4:0] btn_level, btn_press, btn_release, btn_repeat, btn_frame, btn_frame_press;

   int n_assert = 0;
   int n_fail   = 0;

   gamepad_input_conditioner #(
      .N_BTN           (N),
      .ACTIVE_LOW_MASK (MASK),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk_50MHz       (clk),
      .reset           (reset),
      .btn_raw         (btn_raw),
      .frame_tick      (frame_tick),
      .btn_level       (btn_level),
      .btn_press       (btn_press),
      .btn_release     (btn_release),
      .btn_repeat      (btn_repeat),
      .btn_frame       (btn_frame),
      .btn_frame_press (btn_frame_press)
   );

   always #5 clk = ~clk;

   // Reference model: pipeline of two sync samples, mismatch start timestamps,
   // press timestamps for repeat arithmetic, and frame accumulators.
   int         m_t = 0;
   logic [4:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_press = '0, m_rel = '0, m_rep = '0;
   logic [4:0] m_frame = '0, m_fpress = '0, m_acc = '0;
   bit         mm_on    [N];
   int         mm_start [N];
   int         press_t  [N];

   task automatic model_edge();
      logic [4:0] n_lvl, n_press, n_rel, n_rep;
      int d;
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0; m_rep = '0;
         m_frame = '0; m_fpress = '0; m_acc = '0;
         for (int i = 0; i < N; i++) mm_on[i] = 1'b0;
      end else begin
         n_lvl = m_lvl; n_press = '0; n_rel = '0; n_rep = '0;
         for (int i = 0; i < N; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
               if (!mm_on[i]) begin
                  mm_on[i]    = 1'b1;
                  mm_start[i] = m_t;
               end
               if (m_t - mm_start[i] == D - 1) begin
                  n_lvl[i] = m_s2[i];
                  mm_on[i] = 1'b0;
                  if (m_s2[i]) begin
                     n_press[i] = 1'b1;
                     n_rep[i]   = 1'b1;
                     press_t[i] = m_t;
                  end else begin
                     n_rel[i] = 1'b1;
                  end
               end
            end else begin
               mm_on[i] = 1'b0;
            end
            if (m_lvl[i] && !n_rel[i]) begin
               d = m_t - press_t[i];
               if (d == RD || (d > RD && (d - RD) % RP == 0)) n_rep[i] = 1'b1;
            end
         end
         if (frame_tick) begin
            m_frame  = m_lvl;
            m_fpress = m_acc | m_press;
            m_acc    = '0;
         end else begin
            m_acc = m_acc | m_press;
         end
         m_s2 = m_s1;
         m_s1 = btn_raw ^ MASK;
         m_lvl = n_lvl; m_press = n_press; m_rel = n_rel; m_rep = n_rep;
      end
      m_t++;
   endtask

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One clock: update model at the edge, then compare all outputs 1 time unit later
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("level",       btn_level,       m_lvl);
      chk("press",       btn_press,       m_press);
      chk("release",     btn_release,     m_rel);
      chk("repeat",      btn_repeat,      m_rep);
      chk("frame",       btn_frame,       m_frame);
      chk("frame_press", btn_frame_press, m_fpress);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      logic exp_bit;
      int   nhold;

      // Reset state
      idle(3);
      chk("reset_outputs", btn_level | btn_press | btn_release | btn_repeat | btn_frame | btn_frame_press, 5'b0);

      // Press up from edge 1, hold through edge 33, release sampled from edge 34
      reset = 1'b0;
      btn_raw[0] = 1'b0;
      for (int k = 1; k <= 45; k++) begin
         if (k == 34) btn_raw[0] = 1'b1;
         step();
         exp_bit = (k == 6 || k == 16 || k == 19 || k == 22 || k == 25 ||
                    k == 28 || k == 31 || k == 34 || k == 37);
         chk("up_repeat_time", {4'b0, btn_repeat[0]}, {4'b0, exp_bit});
         chk("up_press_time",  {4'b0, btn_press[0]},  {4'b0, (k == 6) ? 1'b1 : 1'b0});
         chk("up_release_time",{4'b0, btn_release[0]},{4'b0, (k == 39) ? 1'b1 : 1'b0});
         chk("up_level_time",  {4'b0, btn_level[0]},  {4'b0, (k >= 6 && k < 39) ? 1'b1 : 1'b0});
      end

      // Short glitches on down (active-low) then shot (active-high)
      btn_raw[1] = 1'b0;
      idle(3);
      btn_raw[1] = 1'b1;
      idle(2);
      btn_raw[4] = 1'b1;
      idle(3);
      btn_raw[4] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("glitch_quiet", btn_level | btn_press | btn_repeat, 5'b0);
      end

      // Left press pulse coincident with frame_tick
      btn_raw[2] = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         frame_tick = (k == 7 || k == 12);
         step();
         if (k == 6) chk("left_press", {4'b0, btn_press[2]}, 5'b00001);
         if (k == 7) chk("left_fpress_set", {4'b0, btn_frame_press[2]}, 5'b00001);
         if (k == 12) chk("left_fpress_clr", {4'b0, btn_frame_press[2]}, 5'b0);
      end
      frame_tick = 1'b0;
      btn_raw[2] = 1'b1;
      idle(10);

      // Reset for one cycle mid-repeat while up is held
      btn_raw[0] = 1'b0;
      idle(20);
      reset = 1'b1;
      step();
      chk("midreset_outputs", btn_level | btn_press | btn_release | btn_repeat | btn_frame | btn_frame_press, 5'b0);
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("post_reset_press", {4'b0, btn_press[0]}, {4'b0, (k == 6) ? 1'b1 : 1'b0});
      end
      btn_raw[0] = 1'b1;
      idle(10);

      // Up and right together, staggered releases
      btn_raw[0] = 1'b0;
      btn_raw[3] = 1'b0;
      for (int k = 1; k <= 6; k++) step();
      chk("dual_press", btn_press, 5'b01001);
      idle(14);
      btn_raw[0] = 1'b1;
      idle(5);
      btn_raw[3] = 1'b1;
      idle(12);

      // Random stimulus with random frame ticks and occasional reset
      for (int s = 0; s < 250; s++) begin
         btn_raw = 5'($urandom);
         nhold   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 25)) : int'($urandom_range(1, 7));
         for (int c = 0; c < nhold; c++) begin
            frame_tick = ($urandom_range(0, 3) == 0);
            reset      = ($urandom_range(0, 149) == 0);
            step();
         end
      end
      reset = 1'b0;
      frame_tick = 1'b0;
      btn_raw = MASK;
      idle(40);
      chk("final_idle_level", btn_level, 5'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
